// File: rtl/crc_32_frame_ctrl.sv
// Frame controller for a parallel CRC-32 datapath.
// Sequences 48-bit lane beats into an external combinational CRC block,
// tracks the running CRC and word count per frame, and holds the final
// result until the consumer takes it.
module crc_32_frame_ctrl #(
  parameter int unsigned PARALLEL_DEPTH = 4,
  parameter logic [31:0] CRC_INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOR_OUT    = 32'hFFFFFFFF
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [PARALLEL_DEPTH*48-1:0] IN_DATA,
  input  logic [PARALLEL_DEPTH-1:0]    IN_KEEP,
  input  logic                         IN_SOF,
  input  logic                         IN_EOF,
  output logic [31:0]                  DP_CRC_IN,
  output logic [PARALLEL_DEPTH-1:0]    DP_VALID,
  output logic [PARALLEL_DEPTH*48-1:0] DP_DATA,
  input  logic [31:0]                  DP_CRC_OUT,
  output logic                         CRC_VALID,
  input  logic                         CRC_READY,
  output logic [31:0]                  CRC_RESULT,
  output logic [15:0]                  LEN_WORDS,
  output logic                         ERR
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] crc_q;
  logic [15:0] len_q;

  logic        accept;
  logic        beat_ok;
  logic        keep_bad;
  logic        err_next;
  logic [31:0] beat_crc;
  logic [15:0] keep_cnt;
  logic [15:0] len_base;
  logic [16:0] len_sum;
  logic [15:0] len_new;

  // Handshake, datapath drive, error detection and next-state selection
  always_comb begin
    state_next = state;
    IN_READY   = (state != HOLD);
    accept     = IN_VALID & IN_READY;
    // Headless beats in IDLE are accepted but not part of any frame
    beat_ok    = accept & (IN_SOF | (state == ACCUM));
    DP_DATA    = IN_DATA;
    DP_VALID   = accept ? IN_KEEP : '0;
    DP_CRC_IN  = (accept & IN_SOF) ? CRC_INIT : crc_q;
    keep_bad   = |(IN_KEEP & (IN_KEEP + PARALLEL_DEPTH'(1)));
    err_next   = accept & (((state == IDLE) & ~IN_SOF) |
                           ((state == ACCUM) & IN_SOF) |
                           keep_bad);
    case (state)
      IDLE:    if (beat_ok) state_next = IN_EOF ? HOLD : ACCUM;
      ACCUM:   if (beat_ok && IN_EOF) state_next = HOLD;
      HOLD:    if (CRC_VALID && CRC_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-beat CRC selection and saturating word count
  always_comb begin
    keep_cnt = '0;
    for (int unsigned i = 0; i < PARALLEL_DEPTH; i++) begin
      keep_cnt = keep_cnt + 16'(IN_KEEP[i]);
    end
    // An empty beat passes the incoming CRC through untouched
    beat_crc = (IN_KEEP == '0) ? DP_CRC_IN : DP_CRC_OUT;
    len_base = IN_SOF ? '0 : len_q;
    len_sum  = {1'b0, len_base} + {1'b0, keep_cnt};
    len_new  = len_sum[16] ? '1 : len_sum[15:0];
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Running CRC/length, result hold register and error pulse
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      crc_q      <= CRC_INIT;
      len_q      <= '0;
      CRC_VALID  <= 1'b0;
      CRC_RESULT <= '0;
      LEN_WORDS  <= '0;
      ERR        <= 1'b0;
    end else begin
      ERR <= err_next;
      if (beat_ok && !IN_EOF) begin
        crc_q <= beat_crc;
        len_q <= len_new;
      end
      if (beat_ok && IN_EOF) begin
        CRC_RESULT <= beat_crc ^ CRC_XOR_OUT;
        LEN_WORDS  <= len_new;
        CRC_VALID  <= 1'b1;
      end
      if ((state == HOLD) && CRC_VALID && CRC_READY) begin
        CRC_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_32_frame_ctrl.sv
// Self-checking bench for crc_32_frame_ctrl: directed protocol scenarios
// plus random frames, compared against a byte-table CRC-32 reference.
module tb_crc_32_frame_ctrl;

  localparam int D = 4;

  logic          CLK;
  logic          RST_N;
  logic          IN_VALID;
  logic          IN_READY;
  logic [D*48-1:0] IN_DATA;
  logic [D-1:0]  IN_KEEP;
  logic          IN_SOF;
  logic          IN_EOF;
  logic [31:0]   DP_CRC_IN;
  logic [D-1:0]  DP_VALID;
  logic [D*48-1:0] DP_DATA;
  logic [31:0]   DP_CRC_OUT;
  logic          CRC_VALID;
  logic          CRC_READY;
  logic [31:0]   CRC_RESULT;
  logic [15:0]   LEN_WORDS;
  logic          ERR;

  int checks = 0;
  int errors = 0;

  // Reference model state: whole-frame CRC over a byte stream
  logic [31:0] tbl [256];
  logic [31:0] m_crc;
  int          m_len;

  crc_32_frame_ctrl #(
    .PARALLEL_DEPTH(D),
    .CRC_INIT      (32'hFFFFFFFF),
    .CRC_XOR_OUT   (32'hFFFFFFFF)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_KEEP   (IN_KEEP),
    .IN_SOF    (IN_SOF),
    .IN_EOF    (IN_EOF),
    .DP_CRC_IN (DP_CRC_IN),
    .DP_VALID  (DP_VALID),
    .DP_DATA   (DP_DATA),
    .DP_CRC_OUT(DP_CRC_OUT),
    .CRC_VALID (CRC_VALID),
    .CRC_READY (CRC_READY),
    .CRC_RESULT(CRC_RESULT),
    .LEN_WORDS (LEN_WORDS),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the external parallel CRC block: reflected CRC-32, lanes in order
  function automatic logic [31:0] dp_fn(input logic [31:0] c_in, input logic [D-1:0] v,
                                        input logic [D*48-1:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < D; i++)
      if (v[i])
        for (int b = 0; b < 48; b++)
          c = (c >> 1) ^ ((c[0] ^ d[i*48+b]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction

  always_comb DP_CRC_OUT = dp_fn(DP_CRC_IN, DP_VALID, DP_DATA);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    m_crc = 32'hFFFFFFFF;
    m_len = 0;
  endtask

  task automatic model_word(input logic [47:0] w);
    logic [7:0] byt;
    for (int b = 0; b < 6; b++) begin
      byt   = w[b*8 +: 8];
      m_crc = (m_crc >> 8) ^ tbl[(m_crc[7:0] ^ byt)];
    end
    m_len++;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    IN_EOF   = 1'b0;
  endtask

  // Drive one beat; it is accepted on the following rising edge
  task automatic beat(input logic sof, input logic eof, input logic [D-1:0] keep,
                      input logic exp_err, input logic upd);
    logic [31:0] exp_in;
    @(posedge CLK); #1;
    chk("err_prev", 32'(ERR), 32'(exp_err));
    for (int i = 0; i < D; i++) IN_DATA[i*48 +: 48] = {16'($urandom), 32'($urandom)};
    IN_KEEP  = keep;
    IN_SOF   = sof;
    IN_EOF   = eof;
    IN_VALID = 1'b1;
    exp_in   = sof ? 32'hFFFFFFFF : m_crc;
    #1;
    chk("in_ready", 32'(IN_READY), 32'd1);
    chk("dp_valid", 32'(DP_VALID), 32'(keep));
    if (upd) begin
      chk("dp_crc_in", DP_CRC_IN, exp_in);
      if (sof) model_start();
      for (int i = 0; i < D; i++) if (keep[i]) model_word(IN_DATA[i*48 +: 48]);
    end
  endtask

  task automatic expect_result();
    chk("crc_valid", 32'(CRC_VALID), 32'd1);
    chk("crc_result", CRC_RESULT, m_crc ^ 32'hFFFFFFFF);
    chk("len_words", 32'(LEN_WORDS), (m_len > 65535) ? 32'hFFFF : 32'(m_len));
    chk("hold_ready", 32'(IN_READY), 32'd0);
  endtask

  task automatic handoff();
    CRC_READY = 1'b1;
    @(posedge CLK); #1;
    CRC_READY = 1'b0;
    chk("handoff_valid", 32'(CRC_VALID), 32'd0);
    chk("handoff_ready", 32'(IN_READY), 32'd1);
    chk("handoff_err", 32'(ERR), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    IN_EOF   = 1'b0;
    CRC_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(IN_READY), 32'd1);
    chk("rst_valid", 32'(CRC_VALID), 32'd0);
    chk("rst_dp_valid", 32'(DP_VALID), 32'd0);
    chk("rst_len", 32'(LEN_WORDS), 32'd0);
    chk("rst_result", CRC_RESULT, 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_ready", 32'(IN_READY), 32'd1);
    chk("post_rst_err", 32'(ERR), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    int nb;
    int k;

    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[n] = c;
    end
    m_crc    = 32'hFFFFFFFF;
    m_len    = 0;
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    IN_KEEP  = '0;
    IN_SOF   = 1'b0;
    IN_EOF   = 1'b0;
    CRC_READY = 1'b0;

    do_reset();

    // Single-beat frame, two lanes
    beat(1'b1, 1'b1, 4'b0011, 1'b0, 1'b1);
    idle();
    expect_result();
    handoff();

    // Three-beat frame, 11 words, then backpressure with a beat offered in HOLD
    beat(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 4'b0111, 1'b0, 1'b1);
    idle();
    expect_result();
    held = CRC_RESULT;
    chk("len_11", 32'(LEN_WORDS), 32'd11);
    IN_VALID = 1'b1; IN_SOF = 1'b1; IN_EOF = 1'b1; IN_KEEP = 4'b1111;
    #1;
    chk("hold_dp_valid", 32'(DP_VALID), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      chk("bp_ready", 32'(IN_READY), 32'd0);
      chk("bp_valid", 32'(CRC_VALID), 32'd1);
      chk("bp_result", CRC_RESULT, m_crc ^ 32'hFFFFFFFF);
    end
    IN_VALID = 1'b0;
    handoff();

    // Headless beat in IDLE: dropped with ERR, length untouched
    beat(1'b0, 1'b0, 4'b0011, 1'b0, 1'b0);
    idle();
    chk("headless_err", 32'(ERR), 32'd1);
    chk("headless_len", 32'(LEN_WORDS), 32'd11);
    chk("headless_valid", 32'(CRC_VALID), 32'd0);
    idle();
    chk("headless_err_clr", 32'(ERR), 32'd0);

    // SOF during ACCUM aborts and restarts with the seed
    beat(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 4'b0011, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    idle();
    expect_result();
    handoff();

    // Non-contiguous keep: ERR, exact mask still processed
    beat(1'b1, 1'b1, 4'b0101, 1'b0, 1'b1);
    idle();
    chk("noncontig_err", 32'(ERR), 32'd1);
    expect_result();
    handoff();

    // Empty beats mid-frame and at EOF, with an idle gap
    beat(1'b1, 1'b0, 4'b0011, 1'b0, 1'b1);
    idle();
    idle();
    beat(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    idle();
    expect_result();
    handoff();

    // Reset mid-frame, then a fresh one-word frame
    beat(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
    do_reset();
    beat(1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    idle();
    expect_result();
    chk("len_1", 32'(LEN_WORDS), 32'd1);

    // Reset while holding a result discards it
    do_reset();

    // Random well-formed frames with gaps and random consumer delay
    for (int f = 0; f < 15; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if (b > 0 && $urandom_range(0, 1) == 1) idle();
        k = $urandom_range(0, 4);
        beat(b == 0, b == nb - 1, 4'((1 << k) - 1), 1'b0, 1'b1);
      end
      idle();
      expect_result();
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
        chk("rand_hold", 32'(CRC_VALID), 32'd1);
      end
      handoff();
    end

    // Length saturation: 16400 full beats = 65600 words
    beat(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    for (int b = 0; b < 16398; b++) beat(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    idle();
    expect_result();
    chk("len_sat", 32'(LEN_WORDS), 32'hFFFF);
    handoff();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_32_frame_ctrl.md
CRC_32_FRAME_CTRL -- requirements
Module: crc_32_frame_ctrl

Interface
REQ-001 Parameters SHALL be: PARALLEL_DEPTH, 4, number of 48-bit lanes per beat.
REQ-002 Parameters SHALL include: CRC_INIT, 32'hFFFFFFFF, seed loaded at frame start.
REQ-003 Parameters SHALL include: CRC_XOR_OUT, 32'hFFFFFFFF, value XORed onto the final CRC.
REQ-004 The block SHALL use one clock, CLK, and a synchronous, active-low reset, RST_N. The ports SHALL be as follows:
- CLK  in  1  clock.
- RST_N  in  1  synchronous active-low reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  input beat accepted when IN_VALID & IN_READY.
- IN_DATA  in  PARALLEL_DEPTH*48  lane i at [i*48+:48].
- IN_KEEP  in  PARALLEL_DEPTH  lane enables; legal values are contiguous from lane 0.
- IN_SOF  in  1  first beat of frame.
- IN_EOF  in  1  last beat of frame.
- DP_CRC_IN  out  32  running CRC presented to the parallel CRC datapath.
- DP_VALID  out  PARALLEL_DEPTH  lane mask to the datapath.
- DP_DATA  out  PARALLEL_DEPTH*48  lane data to the datapath.
- DP_CRC_OUT  in  32  combinational datapath result.
- CRC_VALID  out  1  final CRC available.
- CRC_READY  in  1  consumer takes the result.
- CRC_RESULT  out  32  final CRC.
- LEN_WORDS  out  16  number of 48-bit words in the frame; saturates at 16'hFFFF.
- ERR  out  1  one-cycle protocol-error pulse.

Function
REQ-005 The state machine SHALL have three states: IDLE, ACCUM and HOLD.
REQ-006 IN_READY SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-007 DP_DATA SHALL equal IN_DATA, and DP_VALID SHALL equal IN_KEEP when a beat is accepted and 0 otherwise.
REQ-008 DP_CRC_IN SHALL equal CRC_INIT when the accepted beat has IN_SOF=1; otherwise it SHALL equal the internal running CRC register.
REQ-009 On an accepted beat with IN_EOF=0, the running CRC register SHALL load DP_CRC_OUT and LEN SHALL add popcount(IN_KEEP); on SOF, LEN restarts from 0 before the add.
REQ-010 IDLE + accepted beat with SOF=1, EOF=0 SHALL move to ACCUM.
REQ-011 An accepted beat with SOF=1 and EOF=1 SHALL be a single-beat frame and go directly to HOLD.
REQ-012 IDLE + accepted beat with SOF=0 SHALL drop the beat (no CRC/LEN update), pulse ERR, and stay in IDLE.
REQ-013 ACCUM + accepted beat with EOF=1 SHALL move to HOLD on the next edge.
REQ-014 On entering HOLD: CRC_RESULT <= DP_CRC_OUT ^ CRC_XOR_OUT; LEN_WORDS <= final count; CRC_VALID <= 1.
REQ-015 The result latency SHALL be 1 cycle from the EOF beat's acceptance edge to CRC_VALID high.
REQ-016 ACCUM + accepted beat with SOF=1 SHALL abort the current frame, pulse ERR, and restart the frame using that beat as its first beat (CRC_INIT seed).
REQ-017 An accepted beat with IN_KEEP=0 SHALL leave the CRC and LEN unchanged; if it carries EOF, the frame SHALL close with the current CRC.
REQ-018 A non-contiguous IN_KEEP SHALL pulse ERR; the beat SHALL still be processed using its exact mask.
REQ-019 In HOLD, CRC_RESULT and LEN_WORDS SHALL be stable while CRC_VALID=1.
REQ-020 In HOLD, CRC_VALID & CRC_READY SHALL clear CRC_VALID and return to IDLE on the next edge.
REQ-021 A new beat SHALL be accepted no earlier than the cycle after the result handoff.
REQ-022 LEN SHALL saturate at 16'hFFFF with no wrap.
REQ-023 ERR SHALL be high for exactly one cycle per offending accepted beat.
REQ-024 No internal state SHALL change while IN_VALID=0.

Reset
REQ-025 While RST_N=0 at the clock edge, the following SHALL hold: state = IDLE, running CRC = CRC_INIT, CRC_VALID = 0, CRC_RESULT = 0, LEN_WORDS = 0, ERR = 0.
REQ-026 A reset asserted mid-frame or in HOLD SHALL discard the frame and any pending result with no ERR pulse.
REQ-027 IN_READY SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-028 Reset: hold RST_N=0 for 2 cycles -> IN_READY=1, CRC_VALID=0, DP_VALID=0, LEN_WORDS=0, ERR=0.
REQ-029 Single beat: SOF=1, EOF=1, KEEP=4'b0011 -> DP_CRC_IN=32'hFFFFFFFF, DP_VALID=4'b0011; next cycle CRC_VALID=1, CRC_RESULT=model^32'hFFFFFFFF, LEN_WORDS=2.
REQ-030 Three-beat frame with KEEP 4'b1111, 4'b1111, 4'b0111 -> CRC matches the software CRC-32 over 11 words; LEN_WORDS=11; second beat DP_CRC_IN equals the first beat's DP_CRC_OUT.
REQ-031 Backpressure: CRC_READY=0 for 5 cycles after CRC_VALID -> IN_READY=0, CRC_RESULT stable; CRC_READY=1 -> IN_READY=1 next cycle.
REQ-032 Protocol errors, in sequence:
- headless beat in IDLE -> ERR pulse, no LEN change.
- SOF during ACCUM -> ERR pulse, new frame seeded with 32'hFFFFFFFF.
- KEEP=4'b0101 -> ERR pulse.
REQ-033 Reset mid-frame after 2 beats, then a fresh 1-word frame -> LEN_WORDS=1 and the CRC equals the single-word model.
